// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display bus: glyph table, blank pattern,
// scan-reader FSM states and the decoded-digit record.
package seg7_pkg;

  // Active-high {g,f,e,d,c,b,a}; index is the hex value the glyph represents.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic [3:0] hex;
    logic       point;
    logic       blank;
    logic       err;
  } glyph_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the hex-to-segment decoder: active-low segment and
// point lines back to hex value, point, blank and illegal-glyph flags.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  input  logic       p_n,
  output glyph_t     glyph
);

  logic [6:0] seg;
  logic       hit;

  assign seg = ~seg_n;

  always_comb begin
    glyph       = '0;
    hit         = 1'b0;
    glyph.point = ~p_n;
    if (seg == SEG_BLANK) begin
      // A lone point on a dark digit is not something the drivers emit.
      if (p_n) glyph.blank = 1'b1;
      else     glyph.err   = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seg == SEG_GLYPH[i]) begin
          glyph.hex = 4'(i);
          hit       = 1'b1;
        end
      end
      if (!hit) glyph.err = 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Monitors a multiplexed active-low 7-segment bus, captures each digit once it
// has been stable, and publishes complete frames with a one-cycle strobe.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [6:0]            seg_n,
  input  logic                  p_n,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic [DIGITS-1:0]     point_out,
  output logic [DIGITS-1:0]     blank_out,
  output logic [DIGITS-1:0]     err_out,
  output logic                  frame_valid
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  function automatic logic one_hot_low(input logic [DIGITS-1:0] an);
    return $onehot(~an);
  endfunction

  function automatic logic [IW-1:0] low_index(input logic [DIGITS-1:0] an);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CW'(1);
  endfunction

  logic [DIGITS-1:0]   an_p0;
  logic [6:0]          seg_p0;
  logic                pn_p0;

  logic [DIGITS-1:0]   ref_an;
  logic [6:0]          ref_seg;
  logic                ref_pn;

  scan_state_e         state;
  logic [CW-1:0]       cnt;
  logic [DIGITS-1:0]   seen;

  logic [4*DIGITS-1:0] sh_hex;
  logic [DIGITS-1:0]   sh_point;
  logic [DIGITS-1:0]   sh_blank;
  logic [DIGITS-1:0]   sh_err;

  logic [4*DIGITS-1:0] hex_nxt;
  logic [DIGITS-1:0]   point_nxt;
  logic [DIGITS-1:0]   blank_nxt;
  logic [DIGITS-1:0]   err_nxt;
  logic [DIGITS-1:0]   seen_nxt;

  logic                sample_eq;
  logic [IW-1:0]       slot;
  glyph_t              glyph;

  // Decode always works from the stable reference, never the live sample.
  seg7_glyph_decode u_decode (
    .seg_n (ref_seg),
    .p_n   (ref_pn),
    .glyph (glyph)
  );

  assign sample_eq = (an_p0 == ref_an) && (seg_p0 == ref_seg) && (pn_p0 == ref_pn);
  assign slot      = low_index(ref_an);

  always_comb begin
    hex_nxt   = sh_hex;
    point_nxt = sh_point;
    blank_nxt = sh_blank;
    err_nxt   = sh_err;
    seen_nxt  = seen;
    hex_nxt[4*slot +: 4] = glyph.hex;
    point_nxt[slot]      = glyph.point;
    blank_nxt[slot]      = glyph.blank;
    err_nxt[slot]        = glyph.err;
    seen_nxt[slot]       = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_p0       <= '1;
      seg_p0      <= '1;
      pn_p0       <= 1'b1;
      ref_an      <= '1;
      ref_seg     <= '1;
      ref_pn      <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      seen        <= '0;
      sh_hex      <= '0;
      sh_point    <= '0;
      sh_blank    <= '0;
      sh_err      <= '0;
      hex_out     <= '0;
      point_out   <= '0;
      blank_out   <= '0;
      err_out     <= '0;
      frame_valid <= 1'b0;
    end else begin
      // p0: input sampling stage
      an_p0       <= an_n;
      seg_p0      <= seg_n;
      pn_p0       <= p_n;
      frame_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (one_hot_low(an_p0)) begin
            ref_an  <= an_p0;
            ref_seg <= seg_p0;
            ref_pn  <= pn_p0;
            cnt     <= CW'(1);
            state   <= SETTLE;
          end
        end

        SETTLE: begin
          if (sample_eq) begin
            cnt <= sat_inc(cnt);
            if (sat_inc(cnt) == CNT_MAX) state <= CAPTURE;
          end else if (one_hot_low(an_p0)) begin
            ref_an  <= an_p0;
            ref_seg <= seg_p0;
            ref_pn  <= pn_p0;
            cnt     <= CW'(1);
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
        end

        CAPTURE: begin
          sh_hex   <= hex_nxt;
          sh_point <= point_nxt;
          sh_blank <= blank_nxt;
          sh_err   <= err_nxt;
          if (&seen_nxt) begin
            hex_out     <= hex_nxt;
            point_out   <= point_nxt;
            blank_out   <= blank_nxt;
            err_out     <= err_nxt;
            frame_valid <= 1'b1;
            seen        <= '0;
          end else begin
            seen <= seen_nxt;
          end
          cnt   <= '0;
          state <= HOLD;
        end

        HOLD: begin
          if (!sample_eq) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: scans hand-built frames onto the bus
// and compares published frames against hand-computed values.
module tb_seg7_scan_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 8;

  localparam logic [6:0] G [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic                clk = 1'b0;
  logic                rst_n;
  logic [DIGITS-1:0]   an_n;
  logic [6:0]          seg_n;
  logic                p_n;
  logic [4*DIGITS-1:0] hex_out;
  logic [DIGITS-1:0]   point_out;
  logic [DIGITS-1:0]   blank_out;
  logic [DIGITS-1:0]   err_out;
  logic                frame_valid;

  int checks   = 0;
  int failures = 0;
  int fv_cnt   = 0;
  int base;

  seg7_scan_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .p_n         (p_n),
    .hex_out     (hex_out),
    .point_out   (point_out),
    .blank_out   (blank_out),
    .err_out     (err_out),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid) fv_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic show(input int idx, input logic [6:0] pat, input logic pt, input int cycles);
    an_n  = ~(4'b0001 << idx);
    seg_n = ~pat;
    p_n   = ~pt;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic idle_bus(input int cycles);
    an_n  = '1;
    seg_n = '1;
    p_n   = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic scan4(input logic [15:0] hx);
    for (int d = 3; d >= 0; d--) show(d, G[hx[4*d +: 4]], 1'b0, 20);
  endtask

  initial begin
    rst_n = 1'b0;
    an_n  = '1;
    seg_n = '1;
    p_n   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_hex", hex_out, 0);
    chk("rst_point", point_out, 0);
    chk("rst_blank", blank_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_fv", frame_valid, 0);

    // Basic frame 1234
    base = fv_cnt;
    scan4(16'h1234);
    idle_bus(5);
    chk("f1_count", fv_cnt - base, 1);
    chk("f1_hex", hex_out, 16'h1234);
    chk("f1_point", point_out, 0);
    chk("f1_err", err_out, 0);
    chk("f1_blank", blank_out, 0);

    // Short burst on digit 0 must not complete the frame
    base = fv_cnt;
    show(3, G[1], 1'b0, 20);
    show(2, G[2], 1'b0, 20);
    show(1, G[3], 1'b0, 20);
    show(0, 7'h71, 1'b0, 5);
    idle_bus(3);
    chk("burst_nocap", fv_cnt - base, 0);
    show(0, 7'h71, 1'b0, 20);
    idle_bus(5);
    chk("burst_count", fv_cnt - base, 1);
    chk("burst_nib0", hex_out[3:0], 4'hF);
    chk("burst_hex", hex_out, 16'h123F);

    // Illegal pattern with point on digit 1
    base = fv_cnt;
    show(3, G[1], 1'b0, 20);
    show(2, G[2], 1'b0, 20);
    show(1, 7'h49, 1'b1, 20);
    show(0, G[3], 1'b0, 20);
    idle_bus(5);
    chk("bad_count", fv_cnt - base, 1);
    chk("bad_hex", hex_out, 16'h1203);
    chk("bad_err", err_out, 4'b0010);
    chk("bad_point", point_out, 4'b0010);
    chk("bad_blank", blank_out, 0);

    // Two anodes low, then blanked: nothing captured, outputs held
    base = fv_cnt;
    an_n  = 4'b1001;
    seg_n = ~G[8];
    p_n   = 1'b1;
    repeat (20) @(negedge clk);
    idle_bus(30);
    chk("multi_nofv", fv_cnt - base, 0);
    chk("multi_hold_hex", hex_out, 16'h1203);
    chk("multi_hold_err", err_out, 4'b0010);

    // Partial scan, then a full frame overwriting it, digit 1 dark
    base = fv_cnt;
    show(3, G[7], 1'b0, 20);
    show(2, G[7], 1'b0, 20);
    show(1, G[7], 1'b0, 20);
    idle_bus(5);
    chk("partial_nofv", fv_cnt - base, 0);
    show(3, G[4'hA], 1'b0, 20);
    show(2, G[4'hB], 1'b0, 20);
    show(1, 7'h00, 1'b0, 20);
    show(0, G[4'hD], 1'b0, 20);
    idle_bus(5);
    chk("dark_count", fv_cnt - base, 1);
    chk("dark_hex", hex_out, 16'hAB0D);
    chk("dark_blank", blank_out, 4'b0010);
    chk("dark_err", err_out, 0);
    chk("dark_point", point_out, 0);

    // Reset after three captured digits discards them
    show(3, G[9], 1'b0, 20);
    show(2, G[9], 1'b0, 20);
    show(1, G[9], 1'b0, 20);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_hex", hex_out, 0);
    chk("mid_rst_blank", blank_out, 0);
    base = fv_cnt;
    show(0, G[8], 1'b0, 20);
    chk("post_rst_nofv", fv_cnt - base, 0);
    show(3, G[5], 1'b0, 20);
    show(2, G[6], 1'b0, 20);
    show(1, G[7], 1'b0, 20);
    idle_bus(5);
    chk("post_rst_count", fv_cnt - base, 1);
    chk("post_rst_hex", hex_out, 16'h5678);
    chk("post_rst_err", err_out, 0);
    chk("post_rst_blank", blank_out, 0);
    chk("post_rst_point", point_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Reader for the active-low, time-multiplexed 7-segment display bus driven by the hex-to-segment decoders and digit scanner.
- Watches anode selects plus segment lines a–g and p, and waits for each digit's pattern to be stable.
- Inverse-decodes each stable pattern back to a 4-bit hex value, point bit, blank flag and error flag.
- Publishes a complete multi-digit frame with a one-cycle valid strobe.
- Used as a self-check monitor on the board and as a loopback checker in benches.

Parameters:
- DIGITS, 4: number of scanned digits (anodes).
- STABLE_CYCLES, 8: consecutive identical samples required before a digit is captured; legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- an_n  in  DIGITS  anode selects, active-low; exactly one low means a digit is being driven.
- seg_n  in  7  segments {g,f,e,d,c,b,a}, active-low.
- p_n  in  1  decimal point, active-low.
- hex_out  out  4*DIGITS  captured hex frame; digit k occupies bits [4k+3:4k].
- point_out  out  DIGITS  captured point per digit, 1 = lit.
- blank_out  out  DIGITS  1 = digit was fully dark (segments a–g and p all off).
- err_out  out  DIGITS  1 = segment pattern not a legal hex glyph.
- frame_valid  out  1  one-cycle pulse when hex_out, point_out, blank_out and err_out are updated.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All outputs 0.
  - Shadow registers, seen mask and stable counter cleared.
  - FSM returns to IDLE.
  - Reset mid-frame discards all partially captured digits.
- Input stage:
  - an_n, seg_n and p_n are registered once, giving 1 cycle of input latency.
  - All further logic uses the registered copies.
- Glyph table ({g..a} active-high, i.e. ~seg_n): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Decode of a stable pattern:
  - Pattern in table: hex = table index, err=0, blank=0.
  - ~seg_n=00 and p_n=1: blank=1, hex=0, err=0.
  - ~seg_n=00 and p_n=0: blank=0, hex=0, err=1, point=1 (a point on an otherwise dark digit is flagged as an error).
  - Any other pattern: err=1, hex=0.
  - point = ~p_n in all cases.
- FSM states:
  - IDLE: registered an_n must be one-hot-low. If so, latch the sample as the reference, set cnt=1 and go to SETTLE. Otherwise stay.
  - SETTLE:
    - Sample equals reference: cnt++.
    - Sample differs but is one-hot-low: it becomes the new reference, cnt=1.
    - Sample is not one-hot-low: go to IDLE, cnt=0.
    - When cnt reaches STABLE_CYCLES, go to CAPTURE.
  - CAPTURE (1 cycle):
    - Write the decode into shadow slot k, where k is the low anode index, and set seen[k].
    - If seen becomes all-ones: copy shadow to outputs, pulse frame_valid on the next cycle, clear seen.
    - Then go to HOLD.
  - HOLD: stay while the sample equals the reference. On any change, go to IDLE.
- Capture timing: capture occurs 1 (register) + STABLE_CYCLES cycles after a stable digit appears; frame_valid follows the capture edge of the last missing digit by 1 cycle.
- Frame assembly rules:
  - A digit re-captured before the frame completes overwrites its shadow slot.
  - Digits may arrive in any order; the frame completes when all DIGITS slots are seen.
- Output hold: outputs stay unchanged between frame_valid pulses.
- Blanking: all anodes high (display blanked / LE=1) is a non-one-hot state and is never captured.
- Counter: cnt width is ceil(log2(STABLE_CYCLES+1)) and saturates; it never wraps.

Decomposition:
- Package seg7_pkg holds:
  - SEG_GLYPH[16] constant table shared with the segment drivers.
  - SEG_BLANK constant.
  - FSM state enum {IDLE, SETTLE, CAPTURE, HOLD}.
- One sub-module, seg7_glyph_decode: combinational {seg_n, p_n} -> {hex, point, blank, err}.
- FSM, counter, shadow registers and input register stay in seg7_scan_reader.

Test Plan:
- Scan digits 3,2,1,0 with glyphs 1,2,3,4, 20 cycles each, p_n=1 -> exactly one frame_valid; hex_out=16'h1234, point_out=0, err_out=0, blank_out=0.
- Digit 0 glyph 0x71 held only 5 cycles, then 20 cycles (STABLE_CYCLES=8) -> no capture from the 5-cycle burst; hex_out[3:0]=F after the frame completes.
- Digit 1 pattern ~seg_n=0x49 with p_n=0 -> err_out[1]=1, point_out[1]=1, hex_out[7:4]=0.
- an_n=4'b1001 (two anodes low), then an_n=4'b1111 for 30 cycles -> no capture, frame_valid stays 0, seen mask unchanged.
- Full frame 16'hABCD with a digit all-dark -> blank_out has that bit set, that hex nibble is 0, err_out=0.
- rst_n=0 for 1 cycle after 3 of 4 digits are captured, then a full scan of 16'h5678 -> the single frame_valid shows 16'h5678 with no residue from before reset.
